// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter for the core's console output.
// The line is registered from the FSM state, so it trails the state by one cycle.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       fifo_full,
  output logic       tx_busy,
  output logic       overflow,
  output logic       uart_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_busy;
  logic          r_ovf;
  logic          r_uart;

  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_count;
  logic          w_baud_last;
  logic          w_can_load;
  logic          w_pop;
  logic          w_push;
  logic          w_idle_nxt;
  logic          w_empty_nxt;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_baud_last = (r_baud == CW'(CLKS_PER_BIT - 1));
  assign w_can_load  = (r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last);
  assign w_pop       = w_can_load && !w_empty;
  assign w_push      = wr_en && !w_full;

  // Busy is registered against the post-edge state and FIFO occupancy.
  assign w_idle_nxt  = w_can_load && !w_pop;
  assign w_empty_nxt = ((w_count == PW'(0)) && !w_push) ||
                       ((w_count == PW'(1)) && w_pop && !w_push);

  assign fifo_full = w_full;
  assign tx_busy   = r_busy;
  assign overflow  = r_ovf;
  assign uart_out  = r_uart;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
      r_uart   <= 1'b1;
    end else begin
      if (w_push)             r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)              r_rd_ptr <= r_rd_ptr + PW'(1);
      if (wr_en && w_full)    r_ovf    <= 1'b1;
      r_busy <= !w_idle_nxt || !w_empty_nxt;

      case (r_state)
        S_IDLE: begin
          r_uart <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr[AW-1:0]];
            r_baud  <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_uart <= 1'b0;
          if (w_baud_last) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_DATA: begin
          r_uart <= r_shift[0];
          if (w_baud_last) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_STOP: begin
          r_uart <= 1'b1;
          if (w_baud_last) begin
            r_baud <= '0;
            // Back-to-back frames: reload straight into START with no idle gap.
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr[AW-1:0]];
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-position model, mid-bit receiver,
// and directed scenarios with literal expectations.
module tb_uart_tx_fifo;

  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * C;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_full;
  logic       tx_busy;
  logic       overflow;
  logic       uart_out;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .fifo_full (fifo_full),
    .tx_busy   (tx_busy),
    .overflow  (overflow),
    .uart_out  (uart_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of accepted bytes plus position within the frame being sent.
  logic [7:0] mq[$];
  logic       m_act;
  int         m_t;
  logic [7:0] m_byte;
  logic       m_pre_full;
  logic       m_last;
  logic       m_pop;
  logic       e_uart, e_busy, e_full, e_ovf;

  function automatic logic line_bit(input logic [7:0] b, input int t);
    int idx;
    idx = t / C;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  initial begin
    m_act = 1'b0; m_t = 0; m_byte = '0;
    e_uart = 1'b1; e_busy = 1'b0; e_full = 1'b0; e_ovf = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_act = 1'b0; m_t = 0; m_byte = '0;
      e_uart = 1'b1; e_busy = 1'b0; e_full = 1'b0; e_ovf = 1'b0;
    end else begin
      m_pre_full = (mq.size() == DEPTH);
      m_last     = m_act && (m_t == FRAME - 1);
      e_uart     = m_act ? line_bit(m_byte, m_t) : 1'b1;
      m_pop      = (mq.size() > 0) && (!m_act || m_last);
      if (m_pop) begin
        m_byte = mq.pop_front();
        m_act  = 1'b1;
        m_t    = 0;
      end else if (m_last) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_t++;
      end
      if (wr_en) begin
        if (m_pre_full) e_ovf = 1'b1;
        else            mq.push_back(wr_data);
      end
      e_busy = m_act || (mq.size() != 0);
      e_full = (mq.size() == DEPTH);
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_uart_out",  32'(uart_out),  32'(e_uart));
      chk("model_tx_busy",   32'(tx_busy),   32'(e_busy));
      chk("model_fifo_full", 32'(fifo_full), 32'(e_full));
      chk("model_overflow",  32'(overflow),  32'(e_ovf));
    end
  end

  // Receiver: detects the start edge, samples each bit in its middle.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_on = 1'b0;
  logic       rx_prev = 1'b1;
  int         rx_cnt = 0;
  logic [7:0] rx_sh;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (rx_prev && !uart_out) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
        rx_t.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % C) == (C / 2)) begin
        case (rx_cnt / C)
          0: chk("rx_start_bit", 32'(uart_out), 32'(0));
          9: begin
            chk("rx_stop_bit", 32'(uart_out), 32'(1));
            rx_q.push_back(rx_sh);
            rx_on = 1'b0;
          end
          default: rx_sh = {uart_out, rx_sh[7:1]};
        endcase
      end
    end
    rx_prev = uart_out;
  end

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
  endtask

  task automatic wr_stop();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int  n;
    logic tmo;
    n   = 0;
    tmo = 1'b1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (!tx_busy && !rx_on && uart_out) begin
        tmo = 1'b0;
        break;
      end
    end
    chk("wait_done_timeout", 32'(tmo), 32'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_t.delete();
  endtask

  initial begin
    int  k;
    int  guard;
    logic tmo;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;

    // Reset and idle hold
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_uart_out",  32'(uart_out),  32'(1));
      chk("idle_tx_busy",   32'(tx_busy),   32'(0));
      chk("idle_fifo_full", 32'(fifo_full), 32'(0));
      chk("idle_overflow",  32'(overflow),  32'(0));
    end

    // Single byte 0x55 with latency pinned
    rx_clear();
    wr(8'h55);
    wr_stop();
    chk("lat_uart_n0",  32'(uart_out), 32'(1));
    chk("lat_busy_n0",  32'(tx_busy),  32'(1));
    @(negedge clk);
    chk("lat_uart_n1",  32'(uart_out), 32'(1));
    @(negedge clk);
    chk("lat_uart_n2",  32'(uart_out), 32'(0));
    wait_done(100);
    chk("b55_count", 32'(rx_q.size()), 32'(1));
    if (rx_q.size() > 0) chk("b55_value", 32'(rx_q[0]), 32'h55);

    // Two bytes back-to-back
    rx_clear();
    wr(8'h41);
    wr(8'h42);
    wr_stop();
    wait_done(200);
    chk("pair_count", 32'(rx_q.size()), 32'(2));
    if (rx_q.size() == 2) begin
      chk("pair_b0", 32'(rx_q[0]), 32'h41);
      chk("pair_b1", 32'(rx_q[1]), 32'h42);
      chk("pair_gap", 32'(rx_t[1] - rx_t[0]), 32'(FRAME));
    end

    // Overflow: six writes, sixth dropped
    rx_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) chk("ovf_full_before5", 32'(fifo_full), 32'(0));
      if (i == 5) begin
        chk("ovf_full_after5", 32'(fifo_full), 32'(1));
        chk("ovf_flag_before6", 32'(overflow), 32'(0));
      end
      wr_en   = 1'b1;
      wr_data = 8'(8'h10 + i);
    end
    wr_stop();
    chk("ovf_flag_after6", 32'(overflow),  32'(1));
    chk("ovf_still_full",  32'(fifo_full), 32'(1));
    wait_done(400);
    chk("ovf_count", 32'(rx_q.size()), 32'(5));
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk("ovf_byte", 32'(rx_q[i]), 32'(8'h10 + i));
    chk("ovf_sticky", 32'(overflow), 32'(1));

    // Reset mid-DATA with bytes queued
    rx_clear();
    wr(8'h0F);
    wr(8'hA1);
    wr(8'hA2);
    wr_stop();
    tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!uart_out) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk("rst_start_seen", 32'(tmo), 32'(0));
    repeat (21) @(negedge clk);
    chk("rst_bit4_low", 32'(uart_out), 32'(0));
    chk("rst_busy_pre", 32'(tx_busy),  32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_uart_now", 32'(uart_out),  32'(1));
    chk("rst_busy_now", 32'(tx_busy),   32'(0));
    chk("rst_full_now", 32'(fifo_full), 32'(0));
    chk("rst_ovf_now",  32'(overflow),  32'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx_busy || !uart_out) begin
        chk("rst_quiet_busy", 32'(tx_busy),  32'(0));
        chk("rst_quiet_uart", 32'(uart_out), 32'(1));
      end
    end
    chk("rst_no_frames", 32'(rx_q.size()), 32'(0));
    chk("rst_busy_after", 32'(tx_busy), 32'(0));

    // All byte values round-trip with flow control on fifo_full
    rx_clear();
    k     = 0;
    guard = 0;
    while (k < 256 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (!fifo_full) begin
        wr_en   = 1'b1;
        wr_data = 8'(k);
        k++;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_stop();
    chk("all_write_timeout", 32'(k), 32'(256));
    wait_done(1000);
    chk("all_count", 32'(rx_q.size()), 32'(256));
    for (int i = 0; i < 256 && i < rx_q.size(); i++)
      chk("all_byte", 32'(rx_q[i]), 32'(i));
    chk("all_no_overflow", 32'(overflow), 32'(0));

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
